of_action_arbiter: RTL and testbench

OF_ACTION_ARBITER -- requirements
Module: of_action_arbiter

---
 rtl/of_action_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_of_action_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/of_action_arbiter.sv
// Pairs one exact-match and one wildcard result per packet and issues the winning action (exact > wild > miss).
// Optional statistics counters are enabled with the OF_ACTION_ARBITER_STATS_EN macro.
`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 64
`endif
`ifndef OF_ACTION_CTRL_WIDTH
`define OF_ACTION_CTRL_WIDTH 4
`endif
`ifndef OF_DST_PORT_POS
`define OF_DST_PORT_POS 16
`endif
`ifndef OF_DST_PORT
`define OF_DST_PORT 16
`endif

module of_action_arbiter #(
  parameter int OF_ACTION_DATA_WIDTH = `OF_ACTION_DATA_WIDTH,
  parameter int OF_ACTION_CTRL_WIDTH = `OF_ACTION_CTRL_WIDTH,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            exact_valid,
  input  logic                            exact_hit,
  input  logic [OF_ACTION_DATA_WIDTH-1:0] exact_data,
  input  logic [OF_ACTION_CTRL_WIDTH-1:0] exact_ctrl,
  output logic                            exact_rdy,
  input  logic                            wild_valid,
  input  logic                            wild_hit,
  input  logic [OF_ACTION_DATA_WIDTH-1:0] wild_data,
  input  logic [OF_ACTION_CTRL_WIDTH-1:0] wild_ctrl,
  output logic                            wild_rdy,
  input  logic [15:0]                     miss_port,
  output logic [OF_ACTION_DATA_WIDTH-1:0] action_data_bus,
  output logic [OF_ACTION_CTRL_WIDTH-1:0] action_ctrl_bus,
  output logic                            action_valid,
  input  logic                            action_rdy,
  output logic                            proto_err
`ifdef OF_ACTION_ARBITER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]            exact_hit_cnt,
  output logic [CNT_WIDTH-1:0]            wild_hit_cnt,
  output logic [CNT_WIDTH-1:0]            miss_cnt
`endif
);

  localparam int DW = OF_ACTION_DATA_WIDTH;
  localparam int CW = OF_ACTION_CTRL_WIDTH;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;
  localparam logic [CW-1:0] MISS_CTRL = CW'(1);

  logic [0:0]    state_q, state_d;
  logic          ex_full_q, ex_full_d, ex_hit_q, ex_hit_d;
  logic [DW-1:0] ex_data_q, ex_data_d;
  logic [CW-1:0] ex_ctrl_q, ex_ctrl_d;
  logic          wd_full_q, wd_full_d, wd_hit_q, wd_hit_d;
  logic [DW-1:0] wd_data_q, wd_data_d;
  logic [CW-1:0] wd_ctrl_q, wd_ctrl_d;
  logic          act_vld_q, act_vld_d;
  logic [DW-1:0] act_data_q, act_data_d;
  logic [CW-1:0] act_ctrl_q, act_ctrl_d;
  logic          perr_q, perr_d;

  logic          ex_hit_e, wd_hit_e;
  logic [DW-1:0] ex_data_e, wd_data_e, miss_data, sel_data;
  logic [CW-1:0] ex_ctrl_e, wd_ctrl_e, sel_ctrl;
  logic          fire, accept;

  // A result arriving on the same edge that completes the pair is used directly,
  // which is what lets the arbiter sustain one action every two cycles.
  assign ex_hit_e  = ex_full_q ? ex_hit_q  : exact_hit;
  assign ex_data_e = ex_full_q ? ex_data_q : exact_data;
  assign ex_ctrl_e = ex_full_q ? ex_ctrl_q : exact_ctrl;
  assign wd_hit_e  = wd_full_q ? wd_hit_q  : wild_hit;
  assign wd_data_e = wd_full_q ? wd_data_q : wild_data;
  assign wd_ctrl_e = wd_full_q ? wd_ctrl_q : wild_ctrl;

  assign fire   = (state_q == ST_IDLE) && (ex_full_q || exact_valid) && (wd_full_q || wild_valid);
  assign accept = (state_q == ST_ISSUE) && action_rdy;

  always_comb begin
    miss_data = '0;
    miss_data[`OF_DST_PORT_POS +: `OF_DST_PORT] = miss_port;
    if (ex_hit_e) begin
      sel_data = ex_data_e;
      sel_ctrl = ex_ctrl_e;
    end else if (wd_hit_e) begin
      sel_data = wd_data_e;
      sel_ctrl = wd_ctrl_e;
    end else begin
      sel_data = miss_data;
      sel_ctrl = MISS_CTRL;
    end
  end

  always_comb begin
    state_d    = state_q;
    ex_full_d  = ex_full_q | exact_valid;
    ex_hit_d   = ex_hit_q;
    ex_data_d  = ex_data_q;
    ex_ctrl_d  = ex_ctrl_q;
    wd_full_d  = wd_full_q | wild_valid;
    wd_hit_d   = wd_hit_q;
    wd_data_d  = wd_data_q;
    wd_ctrl_d  = wd_ctrl_q;
    act_vld_d  = act_vld_q;
    act_data_d = act_data_q;
    act_ctrl_d = act_ctrl_q;
    perr_d     = perr_q | (exact_valid & ex_full_q) | (wild_valid & wd_full_q);
    if (exact_valid && !ex_full_q) begin
      ex_hit_d  = exact_hit;
      ex_data_d = exact_data;
      ex_ctrl_d = exact_ctrl;
    end
    if (wild_valid && !wd_full_q) begin
      wd_hit_d  = wild_hit;
      wd_data_d = wild_data;
      wd_ctrl_d = wild_ctrl;
    end
    if (fire) begin
      state_d    = ST_ISSUE;
      act_vld_d  = 1'b1;
      act_data_d = sel_data;
      act_ctrl_d = sel_ctrl;
    end else if (accept) begin
      state_d    = ST_IDLE;
      act_vld_d  = 1'b0;
      act_data_d = '0;
      act_ctrl_d = '0;
      ex_full_d  = 1'b0;
      wd_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ex_full_q  <= 1'b0;
      ex_hit_q   <= 1'b0;
      ex_data_q  <= '0;
      ex_ctrl_q  <= '0;
      wd_full_q  <= 1'b0;
      wd_hit_q   <= 1'b0;
      wd_data_q  <= '0;
      wd_ctrl_q  <= '0;
      act_vld_q  <= 1'b0;
      act_data_q <= '0;
      act_ctrl_q <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_full_q  <= ex_full_d;
      ex_hit_q   <= ex_hit_d;
      ex_data_q  <= ex_data_d;
      ex_ctrl_q  <= ex_ctrl_d;
      wd_full_q  <= wd_full_d;
      wd_hit_q   <= wd_hit_d;
      wd_data_q  <= wd_data_d;
      wd_ctrl_q  <= wd_ctrl_d;
      act_vld_q  <= act_vld_d;
      act_data_q <= act_data_d;
      act_ctrl_q <= act_ctrl_d;
      perr_q     <= perr_d;
    end
  end

  assign exact_rdy       = ~ex_full_q;
  assign wild_rdy        = ~wd_full_q;
  assign action_valid    = act_vld_q;
  assign action_data_bus = act_data_q;
  assign action_ctrl_bus = act_ctrl_q;
  assign proto_err       = perr_q;

`ifdef OF_ACTION_ARBITER_STATS_EN
  logic [1:0]           kind_q;
  logic [CNT_WIDTH-1:0] exh_cnt_q, wdh_cnt_q, miss_cnt_q;

  // kind_q remembers which source won so the counter can bump on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q     <= 2'd0;
      exh_cnt_q  <= '0;
      wdh_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (fire) kind_q <= ex_hit_e ? 2'd0 : (wd_hit_e ? 2'd1 : 2'd2);
      if (accept) begin
        case (kind_q)
          2'd0:    exh_cnt_q  <= exh_cnt_q + CNT_WIDTH'(1);
          2'd1:    wdh_cnt_q  <= wdh_cnt_q + CNT_WIDTH'(1);
          default: miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
        endcase
      end
    end
  end

  assign exact_hit_cnt = exh_cnt_q;
  assign wild_hit_cnt  = wdh_cnt_q;
  assign miss_cnt      = miss_cnt_q;
`else
  // CNT_WIDTH only sizes the counters of the statistics build.
  if (CNT_WIDTH > 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_of_action_arbiter.sv
// Directed bench for of_action_arbiter: a queue-based pairing model checked every cycle, plus literal checks.
module tb_of_action_arbiter;
  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          exact_valid, exact_hit, wild_valid, wild_hit;
  logic [DW-1:0] exact_data, wild_data;
  logic [CW-1:0] exact_ctrl, wild_ctrl;
  logic          exact_rdy, wild_rdy;
  logic [15:0]   miss_port;
  logic [DW-1:0] action_data_bus;
  logic [CW-1:0] action_ctrl_bus;
  logic          action_valid, action_rdy, proto_err;
`ifdef OF_ACTION_ARBITER_STATS_EN
  logic [31:0]   exact_hit_cnt, wild_hit_cnt, miss_cnt;
`endif

  of_action_arbiter #(.OF_ACTION_DATA_WIDTH(DW), .OF_ACTION_CTRL_WIDTH(CW), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .exact_valid(exact_valid), .exact_hit(exact_hit), .exact_data(exact_data),
    .exact_ctrl(exact_ctrl), .exact_rdy(exact_rdy),
    .wild_valid(wild_valid), .wild_hit(wild_hit), .wild_data(wild_data),
    .wild_ctrl(wild_ctrl), .wild_rdy(wild_rdy),
    .miss_port(miss_port),
    .action_data_bus(action_data_bus), .action_ctrl_bus(action_ctrl_bus),
    .action_valid(action_valid), .action_rdy(action_rdy), .proto_err(proto_err)
`ifdef OF_ACTION_ARBITER_STATS_EN
    , .exact_hit_cnt(exact_hit_cnt), .wild_hit_cnt(wild_hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each table holds at most one pending result; a packet's action is
  // decided once both results exist and retires when the consumer takes it.
  typedef struct packed { logic hit; logic [DW-1:0] data; logic [CW-1:0] ctrl; } res_t;
  res_t          exq[$];
  res_t          wdq[$];
  bit            m_pend, m_perr, m_acc;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_ctrl;
  int            m_kind;
  int            m_cnt[3];

  always @(posedge clk) begin
    if (reset) begin
      exq.delete(); wdq.delete();
      m_pend = 0; m_perr = 0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
    end else begin
      m_acc = m_pend && action_rdy;
      if (exact_valid) begin
        if (exq.size() != 0) m_perr = 1;
        else exq.push_back('{exact_hit, exact_data, exact_ctrl});
      end
      if (wild_valid) begin
        if (wdq.size() != 0) m_perr = 1;
        else wdq.push_back('{wild_hit, wild_data, wild_ctrl});
      end
      if (m_acc) begin
        m_cnt[m_kind] = m_cnt[m_kind] + 1;
        exq.delete(); wdq.delete();
        m_pend = 0;
      end else if (!m_pend && exq.size() == 1 && wdq.size() == 1) begin
        m_pend = 1;
        if (exq[0].hit) begin
          m_kind = 0; m_data = exq[0].data; m_ctrl = exq[0].ctrl;
        end else if (wdq[0].hit) begin
          m_kind = 1; m_data = wdq[0].data; m_ctrl = wdq[0].ctrl;
        end else begin
          m_kind = 2; m_data = 64'(miss_port) << 16; m_ctrl = 4'h1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("action_valid", 64'(action_valid), 64'(m_pend));
      chk("action_data", action_data_bus, m_pend ? m_data : 64'h0);
      chk("action_ctrl", 64'(action_ctrl_bus), m_pend ? 64'(m_ctrl) : 64'h0);
      chk("exact_rdy", 64'(exact_rdy), 64'(exq.size() == 0));
      chk("wild_rdy", 64'(wild_rdy), 64'(wdq.size() == 0));
      chk("proto_err", 64'(proto_err), 64'(m_perr));
`ifdef OF_ACTION_ARBITER_STATS_EN
      chk("exact_hit_cnt", 64'(exact_hit_cnt), 64'(m_cnt[0]));
      chk("wild_hit_cnt", 64'(wild_hit_cnt), 64'(m_cnt[1]));
      chk("miss_cnt", 64'(miss_cnt), 64'(m_cnt[2]));
`endif
    end
  end

  // Drives the given strobes for one cycle; returns at the negedge after capture.
  task automatic strobe(input bit ev, input bit eh, input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                        input bit wv, input bit wh, input logic [DW-1:0] wd, input logic [CW-1:0] wc);
    @(negedge clk);
    exact_valid = ev; exact_hit = eh; exact_data = ed; exact_ctrl = ec;
    wild_valid  = wv; wild_hit  = wh; wild_data  = wd; wild_ctrl  = wc;
    @(negedge clk);
    exact_valid = 0; wild_valid = 0;
  endtask

  initial begin
    reset = 1; action_rdy = 0; miss_port = 16'h0;
    exact_valid = 0; exact_hit = 0; exact_data = '0; exact_ctrl = '0;
    wild_valid = 0; wild_hit = 0; wild_data = '0; wild_ctrl = '0;
    @(negedge clk);
    chk_en = 1;
    chk("reset_valid", 64'(action_valid), 64'h0);
    chk("reset_exact_rdy", 64'(exact_rdy), 64'h1);
    @(negedge clk);
    reset = 0;

    // exact hit and wild hit together: exact wins
    action_rdy = 1;
    strobe(1, 1, 64'h1234_0000_0000_00AA, 4'h3, 1, 1, 64'h55, 4'h2);
    chk("p1_valid", 64'(action_valid), 64'h1);
    chk("p1_data", action_data_bus, 64'h1234_0000_0000_00AA);
    chk("p1_ctrl", 64'(action_ctrl_bus), 64'h3);
    @(negedge clk);
    chk("p1_done_valid", 64'(action_valid), 64'h0);
    chk("p1_done_rdy", 64'(exact_rdy & wild_rdy), 64'h1);
`ifdef OF_ACTION_ARBITER_STATS_EN
    chk("p1_exact_cnt", 64'(exact_hit_cnt), 64'h1);
`endif

    // exact miss, wild hit five cycles later
    strobe(1, 0, 64'hDEAD, 4'hF, 0, 0, 64'h0, 4'h0);
    repeat (4) @(negedge clk);
    chk("p2_waiting", 64'(action_valid), 64'h0);
    strobe(0, 0, 64'h0, 4'h0, 1, 1, 64'h0000_0000_0004_0000, 4'h1);
    chk("p2_data", action_data_bus, 64'h0000_0000_0004_0000);
    chk("p2_ctrl", 64'(action_ctrl_bus), 64'h1);
    @(negedge clk);

    // both miss: default action built from miss_port
    miss_port = 16'h0100;
    strobe(1, 0, 64'hFFFF, 4'h7, 1, 0, 64'hEEEE, 4'h6);
    chk("p3_data", action_data_bus, 64'h0000_0000_0100_0000);
    chk("p3_ctrl", 64'(action_ctrl_bus), 64'h1);
    @(negedge clk);
`ifdef OF_ACTION_ARBITER_STATS_EN
    chk("p3_miss_cnt", 64'(miss_cnt), 64'h1);
`endif

    // back-pressure for ten cycles
    action_rdy = 0;
    strobe(1, 0, 64'h0, 4'h0, 1, 1, 64'hABCD_0000_1111_2222, 4'h9);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(action_valid), 64'h1);
      chk("bp_data", action_data_bus, 64'hABCD_0000_1111_2222);
      chk("bp_rdys", 64'({exact_rdy, wild_rdy}), 64'h0);
      @(negedge clk);
    end
    action_rdy = 1;
    @(negedge clk);
    chk("bp_done_valid", 64'(action_valid), 64'h0);
    chk("bp_done_rdys", 64'({exact_rdy, wild_rdy}), 64'h3);

    // second exact strobe into a full buffer is dropped
    action_rdy = 0;
    strobe(1, 1, 64'h0000_0000_0000_0A0A, 4'h5, 0, 0, 64'h0, 4'h0);
    strobe(1, 1, 64'h0000_0000_0000_0B0B, 4'h6, 0, 0, 64'h0, 4'h0);
    strobe(0, 0, 64'h0, 4'h0, 1, 0, 64'h77, 4'h2);
    chk("pe_flag", 64'(proto_err), 64'h1);
    chk("pe_data", action_data_bus, 64'h0000_0000_0000_0A0A);
    chk("pe_ctrl", 64'(action_ctrl_bus), 64'h5);

    // reset while an action is pending
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_valid", 64'(action_valid), 64'h0);
    chk("rst_rdys", 64'({exact_rdy, wild_rdy}), 64'h3);
    chk("rst_perr", 64'(proto_err), 64'h0);
    action_rdy = 1;
    strobe(1, 0, 64'h0, 4'h0, 1, 1, 64'h0000_0000_00C0_FFEE, 4'hC);
    chk("rst_next_data", action_data_bus, 64'h0000_0000_00C0_FFEE);
    @(negedge clk);

    // back-to-back pairs at the two-cycle rate, all hit combinations
    for (int i = 0; i < 4; i++) begin
      miss_port = 16'(16'h0010 << i);
      strobe(1, i[0], 64'(64'h100 + i), 4'(i), 1, i[1], 64'(64'h200 + i), 4'(8 + i));
    end
    @(negedge clk);

    // strobes on the accepting edge are dropped
    action_rdy = 0;
    strobe(1, 1, 64'h1, 4'h1, 1, 1, 64'h2, 4'h2);
    action_rdy = 1; exact_valid = 1; exact_hit = 1; exact_data = 64'h3;
    @(negedge clk);
    exact_valid = 0;
    chk("acc_drop_valid", 64'(action_valid), 64'h0);
    chk("acc_drop_perr", 64'(proto_err), 64'h1);
    chk("acc_drop_rdy", 64'(exact_rdy), 64'h1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
